// File: rtl/l1cache_req_master_if.sv
`default_nettype none
// ============================================================================
// Module      : l1cache_req_master_if
// Description : Request/response bus between the L1 request master and the
//               8-way set-associative L1 cache request port.
//               master : drives address, write data and the request strobes,
//                        receives the cache completion signals.
//               slave  : the cache side of the same bus.
//               Signals: data_addr, wdata, awvalid, wvalid, arvalid (to cache)
//                        rvalid, rdata, r_hit, r_resp, w_hit, w_resp (from cache)
// Revision    : 1.0 - initial release
// ============================================================================
interface l1cache_req_master_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] wdata;
    logic              awvalid;
    logic              wvalid;
    logic              arvalid;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              r_hit;
    logic [1:0]        r_resp;
    logic              w_hit;
    logic [1:0]        w_resp;

    modport master (
        output data_addr, wdata, awvalid, wvalid, arvalid,
        input  rvalid, rdata, r_hit, r_resp, w_hit, w_resp
    );

    modport slave (
        input  data_addr, wdata, awvalid, wvalid, arvalid,
        output rvalid, rdata, r_hit, r_resp, w_hit, w_resp
    );
endinterface
`default_nettype wire

// File: rtl/l1cache_req_master.sv
`default_nettype none
// ============================================================================
// Module      : l1cache_req_master
// Description : Core-side initiator for the L1 cache request port. Core
//               requests are buffered in a small FIFO and issued to the cache
//               one at a time; each request ends in a cache completion or a
//               timeout, and the result is returned on a valid/ready channel.
// Ports       : clk, rst           clock, asynchronous active-high reset
//               req_*              core request channel (valid/ready)
//               rsp_*              response channel to the core (valid/ready)
//               bus                cache request bus (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module l1cache_req_master #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    // core request channel
    input  wire logic              req_valid,
    output logic                   req_ready,
    input  wire logic              req_write,
    input  wire logic [ADDR_W-1:0] req_addr,
    input  wire logic [DATA_W-1:0] req_wdata,
    // core response channel
    output logic                   rsp_valid,
    input  wire logic              rsp_ready,
    output logic                   rsp_write,
    output logic                   rsp_hit,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic                   rsp_timeout,
    // cache request bus
    l1cache_req_master_if.master   bus
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_ent_w = 1 + ADDR_W + DATA_W;

    localparam logic [c_cnt_w-1:0] c_fifo_full = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(TIMEOUT - 1);
    localparam logic [1:0]         c_resp_tmo  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [c_ent_w-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_ent_w-1:0] w_head;
    logic               w_head_write;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_wdata;

    state_t             r_state;

    assign w_full    = (r_count == c_fifo_full);
    assign w_empty   = (r_count == '0);
    // Readiness depends only on fullness: a pop in the same cycle does not
    // open a slot for a simultaneous push.
    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;

    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_head_write = w_head[c_ent_w-1];
    assign w_head_addr  = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign w_head_wdata = w_head[DATA_W-1:0];

    // Storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {req_write, req_addr, req_wdata};
        end
    end

    // Pointers are log2(FIFO_DEPTH) wide, so they wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request sequencer
    // ------------------------------------------------------------------
    logic               r_is_write;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic [ADDR_W-1:0]  r_data_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_arvalid;
    logic               r_rsp_valid;
    logic               r_rsp_write;
    logic               r_rsp_hit;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [1:0]         r_rsp_resp;
    logic               r_rsp_timeout;

    logic               w_done;
    logic               w_tmo;

    // Only the completion type matching the outstanding request counts;
    // the other channel's pulses are dropped.
    assign w_done = r_is_write ? (bus.w_hit || (bus.w_resp != 2'b00))
                               : bus.rvalid;
    assign w_tmo  = (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_is_write    <= 1'b0;
            r_tmo_cnt     <= '0;
            r_data_addr   <= '0;
            r_wdata       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_hit     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_is_write  <= w_head_write;
                        r_data_addr <= w_head_addr;
                        r_wdata     <= w_head_write ? w_head_wdata : '0;
                        r_awvalid   <= w_head_write;
                        r_wvalid    <= w_head_write;
                        r_arvalid   <= !w_head_write;
                        r_tmo_cnt   <= '0;
                        r_state     <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    // Completion takes priority over a timeout on the same edge.
                    if (w_done) begin
                        r_awvalid     <= 1'b0;
                        r_wvalid      <= 1'b0;
                        r_arvalid     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_write   <= r_is_write;
                        if (r_is_write) begin
                            r_rsp_hit   <= bus.w_hit;
                            r_rsp_resp  <= bus.w_resp;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_rsp_hit   <= bus.r_hit;
                            r_rsp_resp  <= bus.r_resp;
                            r_rsp_rdata <= bus.rdata;
                        end
                        r_state <= ST_RESP;
                    end else if (w_tmo) begin
                        r_awvalid     <= 1'b0;
                        r_wvalid      <= 1'b0;
                        r_arvalid     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_write   <= r_is_write;
                        r_rsp_hit     <= 1'b0;
                        r_rsp_resp    <= c_resp_tmo;
                        r_rsp_rdata   <= '0;
                        r_state       <= ST_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_arvalid   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_addr = r_data_addr;
    assign bus.wdata     = r_wdata;
    assign bus.awvalid   = r_awvalid;
    assign bus.wvalid    = r_wvalid;
    assign bus.arvalid   = r_arvalid;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_hit     = r_rsp_hit;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_l1cache_req_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1cache_req_master
// Description : Directed self-checking bench for l1cache_req_master. Inputs
//               are driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1cache_req_master;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic              rsp_hit;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;

    int checks = 0;
    int errors = 0;

    l1cache_req_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    l1cache_req_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_hit(rsp_hit), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .bus(bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_cache_inputs();
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        bus.r_hit  = 1'b0;
        bus.r_resp = 2'b00;
        bus.w_hit  = 1'b0;
        bus.w_resp = 2'b00;
    endtask

    initial begin
        int n;
        int hi;
        logic seen;
        logic [31:0] snap;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        clear_cache_inputs();

        // ---------------- reset state ----------------
        step();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_strobes", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
        check("rst_data_addr", bus.data_addr, 0);
        rst = 1'b0;
        step();

        // ---------------- write hit ----------------
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 20'h00204; req_wdata = 32'hDEADBEEF;
        step();                                   // pushed
        req_valid = 1'b0;
        check("wr_no_strobe_yet", bus.awvalid, 0);
        step();                                   // popped
        check("wr_strobes_c1", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b110);
        check("wr_addr", bus.data_addr, 32'h00204);
        check("wr_wdata", bus.wdata, 32'hDEADBEEF);
        step();
        check("wr_strobes_c2", {bus.awvalid, bus.wvalid}, 2'b11);
        bus.w_hit = 1'b1;                         // cache reply after E2
        step();
        clear_cache_inputs();
        check("wr_strobes_drop", {bus.awvalid, bus.wvalid}, 2'b00);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_fields", {rsp_write, rsp_hit, rsp_resp, rsp_timeout}, 5'b11000);
        check("wr_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wr_rsp_cleared", rsp_valid, 0);

        // ---------------- read hit, ignored w_hit, spurious pulses ----------------
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00204; req_wdata = 32'h11111111;
        step();
        req_valid = 1'b0;
        step();
        check("rd_strobes", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b001);
        check("rd_wdata_zero", bus.wdata, 0);
        bus.w_hit = 1'b1; bus.w_resp = 2'b01;     // wrong-channel completion
        step();
        clear_cache_inputs();
        check("rd_whit_ignored_arvalid", bus.arvalid, 1);
        check("rd_whit_ignored_rsp", rsp_valid, 0);
        bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF; bus.r_hit = 1'b1;
        step();
        clear_cache_inputs();
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_rsp_fields", {rsp_write, rsp_hit, rsp_resp, rsp_timeout}, 5'b01000);
        bus.rvalid = 1'b1; bus.rdata = 32'h12345678; bus.r_hit = 1'b0; bus.w_hit = 1'b1;
        step();                                   // spurious pulses in RESP
        clear_cache_inputs();
        check("resp_spurious_rdata", rsp_rdata, 32'hDEADBEEF);
        check("resp_spurious_hit", rsp_hit, 1);
        check("resp_held_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rd_rsp_cleared", rsp_valid, 0);
        bus.rvalid = 1'b1; bus.w_hit = 1'b1; bus.w_resp = 2'b10;
        step();                                   // spurious pulses in IDLE
        clear_cache_inputs();
        step();
        check("idle_spurious_rsp", rsp_valid, 0);
        check("idle_spurious_strobes", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);

        // ---------------- read timeout ----------------
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00ABC;
        step();
        req_valid = 1'b0;
        hi = 0; n = 0;
        step();
        while (!rsp_valid && n < 40) begin
            if (bus.arvalid) hi++;
            step();
            n++;
        end
        check("tmo_arvalid_cycles", hi, 16);
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_fields", {rsp_timeout, rsp_resp, rsp_hit}, 4'b1110);
        check("tmo_rdata", rsp_rdata, 0);
        check("tmo_strobes_low", bus.arvalid, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // ---------------- completion on the timeout edge ----------------
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00550; req_wdata = 32'hCAFEF00D;
        step();
        req_valid = 1'b0;
        step();                                   // 1st strobe-high sample
        hi = 1; n = 0;
        while (hi < 16 && n < 40) begin
            step();
            if (bus.awvalid) hi++;
            n++;
        end
        check("edge_strobe_count", hi, 16);
        check("edge_no_rsp_yet", rsp_valid, 0);
        bus.w_resp = 2'b10;                       // sampled when counter is TIMEOUT-1
        step();
        clear_cache_inputs();
        check("edge_rsp_valid", rsp_valid, 1);
        check("edge_fields", {rsp_write, rsp_timeout, rsp_resp, rsp_hit}, 5'b10100);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // ---------------- FIFO fill, order, back-pressure ----------------
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = 1'b0;
            req_addr = 20'h01000 + 20'(i * 4);
            step();
            check($sformatf("fill_ready_%0d", i), req_ready, (i < 4) ? 1 : 0);
        end
        req_addr = 20'h01014;                     // 6th request must stall
        step();
        check("fill_stall_ready", req_ready, 0);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!bus.arvalid && n < 8) begin
                step();
                n++;
            end
            check($sformatf("ord_arvalid_%0d", i), bus.arvalid, 1);
            check($sformatf("ord_addr_%0d", i), bus.data_addr, 32'h01000 + 32'(i * 4));
            bus.rvalid = 1'b1; bus.rdata = 32'hA0000000 + 32'(i);
            bus.r_hit = 1'b1; bus.r_resp = 2'(i);
            step();
            clear_cache_inputs();
            check($sformatf("ord_rsp_valid_%0d", i), rsp_valid, 1);
            check($sformatf("ord_rdata_%0d", i), rsp_rdata, 32'hA0000000 + 32'(i));
            check($sformatf("ord_resp_%0d", i), rsp_resp, 32'(i % 4));
            if (i == 0) begin
                snap = rsp_rdata;
                step();
                step();
                check("hold_rdata", rsp_rdata, snap);
                check("hold_valid", rsp_valid, 1);
                check("hold_full", req_ready, 0);
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check($sformatf("ord_cleared_%0d", i), rsp_valid, 0);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.arvalid || rsp_valid) seen = 1'b1;
        end
        check("fill_sixth_dropped", seen, 0);

        // ---------------- asynchronous reset mid-REQ ----------------
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00300; req_wdata = 32'h55AA55AA;
        step();
        req_addr = 20'h00304;
        step();
        req_valid = 1'b0;
        check("mid_awvalid", bus.awvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_strobes", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
        check("arst_addr", bus.data_addr, 0);
        check("arst_wdata", bus.wdata, 0);
        check("arst_rsp", {rsp_valid, rsp_write, rsp_hit, rsp_resp, rsp_timeout}, 0);
        check("arst_req_ready", req_ready, 1);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.awvalid || bus.arvalid || rsp_valid) seen = 1'b1;
        end
        check("post_rst_quiet", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l1cache_req_master.md
# l1cache_req_master

Initiator for the L1 8-way set-associative cache request port: drives `data_addr`/`wdata`/`awvalid`/`arvalid`/`wvalid` and consumes `rvalid`/`rdata`/`w_hit`/`r_hit`/`w_resp`/`r_resp`. Core-side requests are buffered in a small FIFO and issued to the cache one at a time. Each request ends with a cache completion or a timeout, and the result is returned on a valid/ready response channel. The block sits between the core load/store unit and the L1 cache.

## Interface
- `ADDR_W`, 20, byte address width (1 MB space)
- `DATA_W`, 32, data width
- `FIFO_DEPTH`, 4, request FIFO entries (power of two, ≥2)
- `TIMEOUT`, 16, maximum cycles spent in REQ before forced completion (≥2)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  core request valid
- `req_ready`  out  1  FIFO not full; combinational
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  request address
- `req_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  core accepts response
- `rsp_write`  out  1  response belongs to a write
- `rsp_hit`  out  1  cache reported hit
- `rsp_rdata`  out  DATA_W  read data (0 for writes)
- `rsp_resp`  out  2  cache response code
- `rsp_timeout`  out  1  request timed out
- `data_addr`  out  20  cache address
- `wdata`  out  32  cache write data
- `awvalid`, `wvalid`, `arvalid`  out  1 each  cache request strobes
- `rvalid`, `w_hit`, `r_hit`  in  1 each  cache read-valid / hit pulses
- `rdata`  in  32  cache read data
- `w_resp`, `r_resp`  in  2 each  cache response codes

## Operation
- Reset: FIFO emptied; FSM to IDLE; counter cleared. All registered outputs (`rsp_*`, `data_addr`, `wdata`, `awvalid`, `wvalid`, `arvalid`) are 0. `req_ready` is 1 (FIFO empty), including while `rst` is high.
- FIFO push when `req_valid && req_ready`. `req_ready = !full`. A push is refused when full, even if a pop occurs in the same cycle. A push into an empty FIFO becomes visible to the FSM on the next edge. Pointers wrap modulo FIFO_DEPTH. An occupancy counter (width log2(FIFO_DEPTH)+1) distinguishes full from empty.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if FIFO is non-empty, pop the head. Load `data_addr`/`wdata` (wdata = 0 for reads), set `awvalid`+`wvalid` for a write or `arvalid` for a read, clear the counter, and go to REQ.
  - REQ: strobes and address held steady. The counter increments each cycle. Completion is sampled at each edge:
    - Write: `w_hit || w_resp != 0`. Capture `rsp_hit = w_hit`, `rsp_resp = w_resp`, `rsp_rdata = 0`.
    - Read: `rvalid`. Capture `rsp_hit = r_hit`, `rsp_rdata = rdata`, `rsp_resp = r_resp`.
    - On completion: strobes drop, `rsp_valid` = 1, `rsp_timeout` = 0, go to RESP.
    - Timeout: if there is no completion when the counter equals TIMEOUT-1, strobes drop and RESP is entered with `rsp_timeout` = 1, `rsp_hit` = 0, `rsp_rdata` = 0, `rsp_resp` = 2'b11.
    - Completion and timeout on the same edge: completion wins.
  - RESP: `rsp_*` held stable until `rsp_valid && rsp_ready`. At that edge `rsp_valid` clears and the FSM goes to IDLE. The next FIFO entry is popped at the following edge. Only one request is outstanding at a time.
- Cache response inputs are ignored outside REQ (spurious pulses dropped). A read response arriving during a write is ignored, and vice versa.
- Reset mid-operation: the outstanding request and queued requests are discarded; no response is produced.

## Timing
- Push at edge E0 into an empty FIFO → pop at E1, strobes high after E1.
- The cache registers its response at E2. Completion is sampled at E3, and `rsp_valid` is high after E3. With `rsp_ready` = 1, it clears after E4.
- Minimum request-to-response latency: 3 cycles. Back-to-back throughput: 1 request per 4 cycles.
- Timeout: strobes asserted for exactly TIMEOUT cycles, then `rsp_valid`.

## Test plan
- Reset with `rst` high mid-REQ → all outputs 0 and `req_ready` = 1 after the asynchronous assert; no `rsp_valid` after release.
- Write addr 0x00204, wdata 0xDEADBEEF; cache returns `w_hit` = 1, `w_resp` = 0 two cycles after `awvalid` → `rsp_valid` with `rsp_write` = 1, `rsp_hit` = 1, `rsp_resp` = 0, `rsp_timeout` = 0; `awvalid`/`wvalid` high for exactly 2 cycles.
- Read addr 0x00204; cache returns `rvalid` = 1, `rdata` = 0xDEADBEEF, `r_hit` = 1 → `rsp_rdata` = 0xDEADBEEF, `rsp_hit` = 1, `rsp_write` = 0.
- Read with the cache never responding, TIMEOUT = 16 → `arvalid` high 16 cycles, then `rsp_timeout` = 1, `rsp_resp` = 2'b11; completion and timeout on the same edge → `rsp_timeout` = 0.
- Push 5 requests back-to-back with `rsp_ready` = 0 → `req_ready` drops after 4 accepted (+1 popped, so 5 fit, 6th stalls); `rsp_*` held stable; after `rsp_ready` = 1, responses return in push order with correct addresses on `data_addr`.
- Spurious `rvalid`/`w_hit` pulses in IDLE and RESP → no state change; a `w_hit` during a read REQ is ignored.
